banked_mem_arbiter: RTL and testbench
=====================================

# banked_mem_arbiter

Parametrised multi-port, multi-bank on-chip memory with per-bank arbitration, replacing the single-port, fixed-priority memory subsystem in the accelerator's memory path. `NUM_PORTS` requesters (DMA, weight loader, PE array readers) issue word accesses through valid/ready handshakes. Banks are low-order interleaved, and each bank independently grants one requester per cycle. The arbitration policy is runtime-selectable between fixed priority and round-robin, and a saturating counter reports stall cycles for performance tuning.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width.
- `ADDR_WIDTH`, 16, word address width per port.
- `NUM_PORTS`, 4, number of requesters (≥2).
- `NUM_BANKS`, 4, number of banks (power of 2, ≥2).
- `BANK_DEPTH`, 1024, words per bank (power of 2).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `arb_mode`  in  1  0 = fixed priority (lowest port index wins), 1 = round-robin.
- `req_valid`  in  NUM_PORTS  per-port request valid.
- `req_ready`  out  NUM_PORTS  per-port grant; a transfer occurs when valid && ready.
- `req_we`  in  NUM_PORTS  1 = write, 0 = read.
- `req_addr`  in  NUM_PORTS*ADDR_WIDTH  flattened word addresses; port p uses slice p.
- `req_wdata`  in  NUM_PORTS*DATA_WIDTH  flattened write data.
- `rsp_valid`  out  NUM_PORTS  read data valid, one pulse per accepted read.
- `rsp_data`  out  NUM_PORTS*DATA_WIDTH  flattened read data.
- `stall_count`  out  16  saturating count of port-cycles with valid && !ready.

## Operation
- Bank select is `addr[BANK_BITS-1:0]`. Row is the next `ROW_BITS` bits. Upper address bits are ignored, so addresses alias.
- Each bank runs its own arbiter over the ports whose valid request targets that bank. At most one grant per bank per cycle, and ports hitting different banks proceed in parallel.
- Fixed mode: lowest-index contender wins. The round-robin pointer is not updated.
- Round-robin mode: a per-bank pointer `last[b]` holds the last granted port. Priority order starts at `last[b]+1` and wraps modulo NUM_PORTS. `last[b]` updates only on a grant.
- A mode change takes effect in the same cycle. Pointers keep their values across mode changes.
- Writes: the bank row is updated at the edge on which the transfer occurs. Writes produce no response.
- Reads: the row is sampled at the acceptance edge, and `rsp_valid[p]`/`rsp_data[p]` are presented the following cycle.
- `stall_count` increments by the number of stalled ports in that cycle and saturates at 0xFFFF.

## Timing
- `req_ready` is combinational from `req_valid`, `req_addr`, `arb_mode` and the pointers. It is legal for ready to depend on valid. Requesters must hold `addr`/`we`/`wdata` stable while valid && !ready.
- Read latency is exactly 1 cycle from acceptance. Back-to-back reads from one port give back-to-back responses.
- `rsp_data[p]` holds its last value while `rsp_valid[p]` is low.
- Read-after-write to the same address in consecutive cycles returns the new data. There is no same-cycle read/write hazard because each bank serves one access per cycle.
- Reset values:
  - `rsp_valid` = 0, `rsp_data` = 0, `stall_count` = 0.
  - All `last[b]` = NUM_PORTS-1, so port 0 has first priority.
  - `req_ready` = 0 while reset is high.
  - Memory contents are not reset.
- Reset mid-operation: reads accepted in the cycle before reset produce no response. Writes on the reset edge are discarded.

## Structure
- Shared package `mem_arb_pkg`:
  - `arb_mode_e` (`ARB_FIXED`, `ARB_RR`).
  - Localparams `BANK_BITS = $clog2(NUM_BANKS)` and `ROW_BITS = $clog2(BANK_DEPTH)`.
  - Stall-counter width constant `STALL_W = 16`.
- Sub-module `rr_arbiter`: parametrised by `NUM_PORTS`, one instance per bank. Inputs are request vector and mode; outputs are a one-hot grant vector and an internal pointer register with reset.
- The top level contains per-bank request decode, the bank arrays (inferred RAM), per-port response registers and the stall counter.

## Test plan
1. Port 0 writes 0xA5A5A5A5 to addr 0x0010, then reads 0x0010 → `rsp_valid[0]` one cycle after read acceptance, data 0xA5A5A5A5.
2. Fixed mode, ports 1 and 3 both read bank 2 (addr 0x0002) continuously → port 1 granted every cycle, port 3 starved, `stall_count` increments by 1 per cycle.
3. RR mode, all 4 ports request bank 0 for 8 cycles → grant order 0,1,2,3,0,1,2,3 and `stall_count` = 24.
4. Ports 0–3 access addrs 0x0,0x1,0x2,0x3 (distinct banks) in one cycle → all `req_ready` = 1, four responses the next cycle.
5. Accepted read followed by reset asserted next edge → no `rsp_valid`. After reset, pointers restart with port 0 winning a 4-way RR conflict.
6. Force 70000 stall port-cycles → `stall_count` saturates at 0xFFFF and does not wrap.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the banked memory arbiter.
// Per-instance widths derive from module parameters; these are defaults.
package mem_arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int NUM_BANKS_DEF  = 4;
  localparam int BANK_DEPTH_DEF = 1024;
  localparam int BANK_BITS      = $clog2(NUM_BANKS_DEF);
  localparam int ROW_BITS       = $clog2(BANK_DEPTH_DEF);
  localparam int STALL_W        = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Per-bank arbiter: fixed priority or round-robin with a grant pointer.
// The pointer only advances on a round-robin grant.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt
);

  localparam int PW = $clog2(NUM_PORTS);

  logic [PW-1:0] last_q;
  logic [PW-1:0] last_d;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt    = '0;
    last_d = last_q;
    found  = 1'b0;
    idx    = '0;
    if (mode == ARB_FIXED) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!found && req[i]) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end else begin
      // Search starts just after the last winner.
      for (int i = 1; i <= NUM_PORTS; i++) begin
        idx = PW'((int'(last_q) + i) % NUM_PORTS);
        if (!found && req[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
          last_d   = idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= PW'(NUM_PORTS - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/banked_mem_arbiter.sv
// Multi-port, low-order interleaved banked memory.
// Each bank arbitrates independently; reads return after one cycle.
module banked_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_PORTS  = 4,
  parameter int NUM_BANKS  = NUM_BANKS_DEF,
  parameter int BANK_DEPTH = BANK_DEPTH_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            arb_mode,
  input  logic [NUM_PORTS-1:0]            req_valid,
  output logic [NUM_PORTS-1:0]            req_ready,
  input  logic [NUM_PORTS-1:0]            req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]            rsp_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_data,
  output logic [STALL_W-1:0]              stall_count
);

  localparam int BSEL_W = $clog2(NUM_BANKS);
  localparam int ROW_W  = $clog2(BANK_DEPTH);
  localparam int DW     = DATA_WIDTH;
  localparam int AW     = ADDR_WIDTH;
  localparam int SW1    = STALL_W + 1;

  logic [DW-1:0]        mem [NUM_BANKS][BANK_DEPTH];

  logic [BSEL_W-1:0]    port_bank [NUM_PORTS];
  logic [ROW_W-1:0]     port_row  [NUM_PORTS];
  logic [NUM_PORTS-1:0] bank_req  [NUM_BANKS];
  logic [NUM_PORTS-1:0] bank_gnt  [NUM_BANKS];
  logic                 bank_we   [NUM_BANKS];
  logic [ROW_W-1:0]     bank_row  [NUM_BANKS];
  logic [DW-1:0]        bank_wd   [NUM_BANKS];
  logic [DW-1:0]        bank_rd   [NUM_BANKS];

  logic [NUM_PORTS-1:0]    rsp_valid_q, rsp_valid_d;
  logic [NUM_PORTS*DW-1:0] rsp_data_q,  rsp_data_d;
  logic [STALL_W-1:0]      stall_q,     stall_d;
  logic [SW1-1:0]          stall_sum;

  // Requests are masked during reset so nothing is granted.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_bank[p] = BSEL_W'(req_addr[p*AW +: AW]);
      port_row[p]  = ROW_W'(req_addr[p*AW +: AW] >> BSEL_W);
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_req[b] = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        bank_req[b][p] = req_valid[p] & ~reset &
                         (port_bank[p] == BSEL_W'(b));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_arb
    rr_arbiter #(
      .NUM_PORTS (NUM_PORTS)
    ) u_arb (
      .clk   (clk),
      .reset (reset),
      .mode  (arb_mode),
      .req   (bank_req[b]),
      .gnt   (bank_gnt[b])
    );
  end

  always_comb begin
    req_ready = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      req_ready = req_ready | bank_gnt[b];
      bank_we[b]  = 1'b0;
      bank_row[b] = '0;
      bank_wd[b]  = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (bank_gnt[b][p]) begin
          bank_we[b]  = req_we[p];
          bank_row[b] = port_row[p];
          bank_wd[b]  = req_wdata[p*DW +: DW];
        end
      end
      bank_rd[b] = mem[b][bank_row[b]];
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_we[b]) begin
        mem[b][bank_row[b]] <= bank_wd[b];
      end
    end
  end

  always_comb begin
    rsp_valid_d = req_ready & ~req_we;
    rsp_data_d  = rsp_data_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rsp_valid_d[p]) begin
        rsp_data_d[p*DW +: DW] = bank_rd[port_bank[p]];
      end
    end
    stall_sum = {1'b0, stall_q};
    for (int p = 0; p < NUM_PORTS; p++) begin
      stall_sum = stall_sum + SW1'(req_valid[p] & ~req_ready[p]);
    end
    stall_d = stall_sum[STALL_W] ? '1 : stall_sum[STALL_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      stall_q     <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      stall_q     <= stall_d;
    end
  end

  // A read accepted just before reset must not surface a response.
  assign rsp_valid   = rsp_valid_q & {NUM_PORTS{~reset}};
  assign rsp_data    = rsp_data_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_banked_mem_arbiter.sv
// Directed bench for banked_mem_arbiter with immediate-assertion checks.
// Inputs change 1ns after posedge; combinational outputs checked at negedge.
module tb_banked_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        arb_mode;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [3:0]  req_we;
  logic [63:0] req_addr;
  logic [127:0] req_wdata;
  logic [3:0]  rsp_valid;
  logic [127:0] rsp_data;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  banked_mem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .arb_mode    (arb_mode),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .stall_count (stall_count)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    req_we    = '0;
  endtask

  task automatic drive(input int p, input logic we,
                       input logic [15:0] a, input logic [31:0] d);
    req_valid[p]          = 1'b1;
    req_we[p]             = we;
    req_addr[p*16 +: 16]  = a;
    req_wdata[p*32 +: 32] = d;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [3:0] rr_exp [8];

  initial begin
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
               4'b0001, 4'b0010, 4'b0100, 4'b1000};
    reset     = 1'b1;
    arb_mode  = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;

    // Reset: ready held low even with a valid request.
    tick();
    drive(0, 1'b0, 16'h0000, 32'h0);
    @(negedge clk);
    check("ready_in_reset", 32'(req_ready), 32'h0);
    tick();
    idle();
    reset = 1'b0;
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data0", rsp_data[31:0], 32'h0);
    check("rst_stall", 32'(stall_count), 32'h0);

    // 1: write then read back on port 0.
    drive(0, 1'b1, 16'h0010, 32'hA5A5A5A5);
    @(negedge clk);
    check("t1_wr_ready", 32'(req_ready), 32'h1);
    tick();
    drive(0, 1'b0, 16'h0010, 32'h0);
    @(negedge clk);
    check("t1_rd_ready", 32'(req_ready), 32'h1);
    check("t1_wr_no_rsp", 32'(rsp_valid), 32'h0);
    tick();
    idle();
    check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t1_rsp_data", rsp_data[31:0], 32'hA5A5A5A5);
    tick();
    check("t1_rsp_drop", 32'(rsp_valid), 32'h0);
    check("t1_data_hold", rsp_data[31:0], 32'hA5A5A5A5);

    // 2: fixed priority, ports 1 and 3 on bank 2.
    do_reset();
    arb_mode = 1'b0;
    drive(1, 1'b0, 16'h0002, 32'h0);
    drive(3, 1'b0, 16'h0002, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("t2_ready", 32'(req_ready), 32'h2);
      tick();
      check("t2_stall", 32'(stall_count), 32'(k));
      check("t2_rsp_valid", 32'(rsp_valid), 32'h2);
    end

    // 3: round-robin, four ports on bank 0.
    do_reset();
    arb_mode = 1'b1;
    for (int p = 0; p < 4; p++) drive(p, 1'b0, 16'h0000, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t3_rr_grant", 32'(req_ready), 32'(rr_exp[i]));
      tick();
    end
    idle();
    check("t3_stall", 32'(stall_count), 32'd24);

    // Pointers survive a mode change and freeze in fixed mode.
    drive(3, 1'b0, 16'h0000, 32'h0);
    tick();
    idle();
    arb_mode = 1'b0;
    drive(1, 1'b0, 16'h0000, 32'h0);
    drive(2, 1'b0, 16'h0000, 32'h0);
    @(negedge clk);
    check("mode_fixed_win", 32'(req_ready), 32'h2);
    tick();
    arb_mode = 1'b1;
    @(negedge clk);
    check("mode_rr_keep_ptr", 32'(req_ready), 32'h2);
    tick();
    idle();

    // 4: four banks in parallel, write then read back.
    for (int p = 0; p < 4; p++)
      drive(p, 1'b1, 16'(p), 32'h11110000 + 32'(p));
    @(negedge clk);
    check("t4_wr_ready", 32'(req_ready), 32'hF);
    tick();
    for (int p = 0; p < 4; p++) drive(p, 1'b0, 16'(p), 32'h0);
    @(negedge clk);
    check("t4_rd_ready", 32'(req_ready), 32'hF);
    tick();
    idle();
    check("t4_rsp_valid", 32'(rsp_valid), 32'hF);
    check("t4_data0", rsp_data[31:0], 32'h11110000);
    check("t4_data1", rsp_data[63:32], 32'h11110001);
    check("t4_data2", rsp_data[95:64], 32'h11110002);
    check("t4_data3", rsp_data[127:96], 32'h11110003);

    // 5: read then reset kills the response; pointers restart.
    arb_mode = 1'b1;
    drive(2, 1'b0, 16'h0000, 32'h0);
    tick();
    idle();
    drive(0, 1'b0, 16'h0001, 32'h0);
    @(negedge clk);
    check("t5_rd_ready", 32'(req_ready), 32'h1);
    tick();
    idle();
    reset = 1'b1;
    #1;
    check("t5_rsp_killed", 32'(rsp_valid), 32'h0);
    tick();
    reset = 1'b0;
    check("t5_rsp_after", 32'(rsp_valid), 32'h0);
    for (int p = 0; p < 4; p++) drive(p, 1'b0, 16'h0000, 32'h0);
    @(negedge clk);
    check("t5_ptr_reset", 32'(req_ready), 32'h1);
    tick();
    idle();

    // 6: saturation, three stalled ports per cycle.
    do_reset();
    arb_mode = 1'b0;
    for (int p = 0; p < 4; p++) drive(p, 1'b0, 16'h0000, 32'h0);
    for (int i = 0; i < 21844; i++) tick();
    check("t6_pre_sat", 32'(stall_count), 32'd65532);
    tick();
    check("t6_sat_exact", 32'(stall_count), 32'hFFFF);
    tick();
    check("t6_sat_hold", 32'(stall_count), 32'hFFFF);
    for (int i = 0; i < 1488; i++) tick();
    check("t6_sat_70000", 32'(stall_count), 32'hFFFF);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
